// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot context iterator: context phases,
// fixed-point constants and the signed product bit-select.
package mandel_pkg;

    // Life cycle of one pixel context.
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_CALC_1 = 3'd1,
        PH_CALC_2 = 3'd2,
        PH_CALC_3 = 3'd3,
        PH_DONE   = 3'd4
    } phase_e;

    // Default fixed-point format Q4.23.
    localparam int FX_WIDTH = 27;
    localparam int FX_FRAC  = 23;
    localparam logic [FX_WIDTH-1:0] ONE_P  = FX_WIDTH'(1) << FX_FRAC;
    localparam logic [FX_WIDTH-1:0] FOUR_P = FX_WIDTH'(1) << (FX_FRAC + 2);

    // Widest word the bit-select helper handles.
    localparam int FX_MAX_W = 64;
    localparam int FX_IDX_W = $clog2(2 * FX_MAX_W);

    // Re-scale a sign-extended full product back to a w-bit word with frac
    // fraction bits: keep the product sign, drop the top integer bits (wrap).
    function automatic logic [FX_MAX_W-1:0] fx_select(input logic [2*FX_MAX_W-1:0] p,
                                                       input int w,
                                                       input int frac);
        logic [FX_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < FX_MAX_W; i++) begin
            if (i < w - 1) begin
                r[i] = p[FX_IDX_W'(i + frac)];
            end else if (i == w - 1) begin
                r[i] = p[FX_IDX_W'(2 * w - 1)];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mandel_fx_mult.sv
// Signed WIDTH x WIDTH fixed-point multiply, result re-scaled to WIDTH bits
// (wraps, no saturation). WIDTH must not exceed 64.
module mandel_fx_mult
    import mandel_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int FRAC  = 23
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] full_s;

    assign full_s = a * b;
    assign p      = WIDTH'(fx_select((2 * FX_MAX_W)'(full_s), WIDTH, FRAC));

endmodule

// File: rtl/mandel_iter_ctx.sv
// Multi-context Mandelbrot escape-time iterator. NUM_CTX pixels share one
// multiplier round-robin; results return tagged, possibly out of order.
// Optional feature macro MANDEL_PERF_CNT_EN adds the perf_iters counter port.
module mandel_iter_ctx
    import mandel_pkg::*;
#(
    parameter int WIDTH    = 27,
    parameter int FRAC     = 23,
    parameter int ITER_MAX = 1000,
    parameter int NUM_CTX  = 4,
    parameter int ID_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [WIDTH-1:0]            in_c_r,
    input  logic [WIDTH-1:0]            in_c_i,
    input  logic [ID_W-1:0]             in_id,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [ID_W-1:0]             out_id,
    output logic [$clog2(ITER_MAX):0]   out_iter,
    output logic                        out_escaped
`ifdef MANDEL_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_iters
`endif
);

    localparam int PTR_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int IT_W  = $clog2(ITER_MAX) + 1;
    localparam logic signed [WIDTH-1:0] FOUR_L = WIDTH'(1) << (FRAC + 2);

    phase_e                   phase_r [NUM_CTX];
    logic signed [WIDTH-1:0]  zr_r    [NUM_CTX];
    logic signed [WIDTH-1:0]  zi_r    [NUM_CTX];
    logic signed [WIDTH-1:0]  cr_r    [NUM_CTX];
    logic signed [WIDTH-1:0]  ci_r    [NUM_CTX];
    logic signed [WIDTH-1:0]  zr_sq_r [NUM_CTX];
    logic signed [WIDTH-1:0]  zi_sq_r [NUM_CTX];
    logic [IT_W-1:0]          iter_r  [NUM_CTX];
    logic [ID_W-1:0]          id_r    [NUM_CTX];
    logic                     esc_r   [NUM_CTX];

    logic [PTR_W-1:0]         ptr_r;
    logic                     alive_r;
    logic                     lock_r;
    logic [PTR_W-1:0]         sel_r;

    logic                     any_idle_s, any_done_s, load_s, accept_s;
    logic [PTR_W-1:0]         load_idx_s, done_idx_s, sel_s;
    phase_e                   cur_phase_s;
    logic signed [WIDTH-1:0]  mul_a_s, mul_b_s, prod_s;
    logic signed [WIDTH-1:0]  mag_s, zr_new_s, zi_new_s;
    logic                     mag_esc_s, lim_s;

    // Find the lowest-index idle context (load target) and lowest DONE context.
    always_comb begin
        any_idle_s = 1'b0;
        any_done_s = 1'b0;
        load_idx_s = '0;
        done_idx_s = '0;
        for (int k = NUM_CTX - 1; k >= 0; k--) begin
            if (phase_r[k] == PH_IDLE) begin
                any_idle_s = 1'b1;
                load_idx_s = PTR_W'(k);
            end else if (phase_r[k] == PH_DONE) begin
                any_done_s = 1'b1;
                done_idx_s = PTR_W'(k);
            end else begin
                // context is iterating: neither loadable nor presentable
            end
        end
    end

    assign in_rdy      = alive_r & any_idle_s;
    assign load_s      = in_val & in_rdy;
    assign sel_s       = lock_r ? sel_r : done_idx_s;
    assign out_val     = lock_r | any_done_s;
    assign accept_s    = out_val & out_rdy;
    assign out_id      = out_val ? id_r[sel_s]   : '0;
    assign out_iter    = out_val ? iter_r[sel_s] : '0;
    assign out_escaped = out_val ? esc_r[sel_s]  : 1'b0;

    // Steer the scheduled context's operands into the shared multiplier.
    always_comb begin
        cur_phase_s = phase_r[ptr_r];
        mul_a_s     = '0;
        mul_b_s     = '0;
        case (cur_phase_s)
            PH_CALC_1: begin
                mul_a_s = zr_r[ptr_r];
                mul_b_s = zr_r[ptr_r];
            end
            PH_CALC_2: begin
                mul_a_s = zi_r[ptr_r];
                mul_b_s = zi_r[ptr_r];
            end
            PH_CALC_3: begin
                mul_a_s = zr_r[ptr_r];
                mul_b_s = zi_r[ptr_r];
            end
            default: begin
                mul_a_s = '0;
                mul_b_s = '0;
            end
        endcase
    end

    mandel_fx_mult #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (prod_s)
    );

    // Escape test on pre-update values and the z update for a CALC_3 step.
    always_comb begin
        mag_s     = zr_sq_r[ptr_r] + zi_sq_r[ptr_r];
        mag_esc_s = (mag_s > FOUR_L) | mag_s[WIDTH-1];
        lim_s     = (iter_r[ptr_r] == IT_W'(ITER_MAX - 1));
        zr_new_s  = zr_sq_r[ptr_r] - zi_sq_r[ptr_r] + cr_r[ptr_r];
        zi_new_s  = (prod_s <<< 1) + ci_r[ptr_r];
    end

    // Round-robin scheduler pointer and the post-reset ready enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r   <= '0;
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (ptr_r == PTR_W'(NUM_CTX - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

    // Output selection lock: hold the presented context until it is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r <= 1'b0;
            sel_r  <= '0;
        end else if (accept_s) begin
            lock_r <= 1'b0;
            sel_r  <= '0;
        end else if (out_val) begin
            lock_r <= 1'b1;
            sel_r  <= sel_s;
        end else begin
            lock_r <= 1'b0;
            sel_r  <= sel_r;
        end
    end

    // Per-context state: load, unload, and one phase step on the context's turn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CTX; k++) begin
                phase_r[k] <= PH_IDLE;
                zr_r[k]    <= '0;
                zi_r[k]    <= '0;
                cr_r[k]    <= '0;
                ci_r[k]    <= '0;
                zr_sq_r[k] <= '0;
                zi_sq_r[k] <= '0;
                iter_r[k]  <= '0;
                id_r[k]    <= '0;
                esc_r[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CTX; k++) begin
                if (load_s && (load_idx_s == PTR_W'(k))) begin
                    phase_r[k] <= PH_CALC_1;
                    zr_r[k]    <= '0;
                    zi_r[k]    <= '0;
                    cr_r[k]    <= in_c_r;
                    ci_r[k]    <= in_c_i;
                    zr_sq_r[k] <= '0;
                    zi_sq_r[k] <= '0;
                    iter_r[k]  <= '0;
                    id_r[k]    <= in_id;
                    esc_r[k]   <= 1'b0;
                end else if (accept_s && (sel_s == PTR_W'(k))) begin
                    phase_r[k] <= PH_IDLE;
                end else if (ptr_r == PTR_W'(k)) begin
                    case (phase_r[k])
                        PH_CALC_1: begin
                            zr_sq_r[k] <= prod_s;
                            phase_r[k] <= PH_CALC_2;
                        end
                        PH_CALC_2: begin
                            zi_sq_r[k] <= prod_s;
                            phase_r[k] <= PH_CALC_3;
                        end
                        PH_CALC_3: begin
                            zr_r[k]    <= zr_new_s;
                            zi_r[k]    <= zi_new_s;
                            iter_r[k]  <= iter_r[k] + IT_W'(1);
                            esc_r[k]   <= mag_esc_s;
                            phase_r[k] <= (mag_esc_s || lim_s) ? PH_DONE : PH_CALC_1;
                        end
                        default: begin
                            phase_r[k] <= phase_r[k];
                        end
                    endcase
                end else begin
                    phase_r[k] <= phase_r[k];
                end
            end
        end
    end

`ifdef MANDEL_PERF_CNT_EN
    logic [31:0] perf_r;

    // Count every executed CALC_3 step across all contexts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_r <= '0;
        end else if (cur_phase_s == PH_CALC_3) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_iters = perf_r;
`endif

endmodule

// File: tb/tb_mandel_iter_ctx.sv
// Directed self-checking bench for mandel_iter_ctx. Two instances share clock
// and reset: dut1 with one context (exact latencies), dut4 with four contexts
// (ordering, stall, reset). Words are Q9.23 so |z|^2 = 10 stays representable.
module tb_mandel_iter_ctx;

    localparam int W   = 32;
    localparam int F   = 23;
    localparam int IM  = 16;
    localparam int IDW = 8;
    localparam int ITW = $clog2(IM) + 1;
    localparam logic [W-1:0] ONE      = 32'h0080_0000;  // 1.0
    localparam logic [W-1:0] TWO_HALF = 32'h0140_0000;  // 2.5

    logic clk = 1'b0;
    logic rst_n;

    logic           in_val1, in_rdy1, out_val1, out_rdy1, out_esc1;
    logic [W-1:0]   in_cr1, in_ci1;
    logic [IDW-1:0] in_id1, out_id1;
    logic [ITW-1:0] out_iter1;

    logic           in_val4, in_rdy4, out_val4, out_rdy4, out_esc4;
    logic [W-1:0]   in_cr4, in_ci4;
    logic [IDW-1:0] in_id4, out_id4;
    logic [ITW-1:0] out_iter4;

`ifdef MANDEL_PERF_CNT_EN
    logic [31:0]    perf1, perf4;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mandel_iter_ctx #(.WIDTH(W), .FRAC(F), .ITER_MAX(IM), .NUM_CTX(1), .ID_W(IDW)) dut1 (
        .clk (clk), .reset (rst_n),
        .in_val (in_val1), .in_rdy (in_rdy1), .in_c_r (in_cr1), .in_c_i (in_ci1), .in_id (in_id1),
        .out_val (out_val1), .out_rdy (out_rdy1), .out_id (out_id1), .out_iter (out_iter1),
        .out_escaped (out_esc1)
`ifdef MANDEL_PERF_CNT_EN
        , .perf_iters (perf1)
`endif
    );

    mandel_iter_ctx #(.WIDTH(W), .FRAC(F), .ITER_MAX(IM), .NUM_CTX(4), .ID_W(IDW)) dut4 (
        .clk (clk), .reset (rst_n),
        .in_val (in_val4), .in_rdy (in_rdy4), .in_c_r (in_cr4), .in_c_i (in_ci4), .in_id (in_id4),
        .out_val (out_val4), .out_rdy (out_rdy4), .out_id (out_id4), .out_iter (out_iter4),
        .out_escaped (out_esc4)
`ifdef MANDEL_PERF_CNT_EN
        , .perf_iters (perf4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue1(input logic [W-1:0] cr, input logic [W-1:0] ci, input logic [IDW-1:0] id);
        @(negedge clk);
        in_val1 = 1'b1;
        in_cr1  = cr;
        in_ci1  = ci;
        in_id1  = id;
        @(posedge clk);
        #1;
        in_val1 = 1'b0;
    endtask

    task automatic wait_val1(input int budget, output int cycles);
        cycles = 0;
        while (out_val1 !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic wait_val4(input int budget, output int cycles);
        cycles = 0;
        while (out_val4 !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic accept1();
        @(negedge clk);
        out_rdy1 = 1'b1;
        @(posedge clk);
        #1;
        out_rdy1 = 1'b0;
    endtask

    task automatic accept4();
        @(negedge clk);
        out_rdy4 = 1'b1;
        @(posedge clk);
        #1;
        out_rdy4 = 1'b0;
    endtask

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] tab_cr [4];
        logic [W-1:0] tab_ci [4];
        int  cyc;
        logic stable;
        logic stale;

        tab_cr = '{32'd0, ONE, 32'd0, TWO_HALF};
        tab_ci = '{32'd0, ONE, 32'd0, 32'd0};

        in_val1 = 1'b0; in_cr1 = '0; in_ci1 = '0; in_id1 = '0; out_rdy1 = 1'b0;
        in_val4 = 1'b0; in_cr4 = '0; in_ci4 = '0; in_id4 = '0; out_rdy4 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_rdy1",  in_rdy1, 0);
        chk("rst_out_val1", out_val1, 0);
        chk("rst_in_rdy4",  in_rdy4, 0);
        chk("rst_out_val4", out_val4, 0);
        chk("rst_out_id4",  out_id4, 0);
        chk("rst_out_iter4", out_iter4, 0);
        chk("rst_out_esc4", out_esc4, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_rdy1", in_rdy1, 1);
        chk("rel_in_rdy4", in_rdy4, 1);

        // Single context, c=0: runs to the limit, 16 iterations x 3 cycles
        issue1(32'd0, 32'd0, 8'd5);
        chk("c0_in_rdy_busy", in_rdy1, 0);
        wait_val1(200, cyc);
        chk("c0_latency", cyc, 48);
        chk("c0_out_id", out_id1, 5);
        chk("c0_out_iter", out_iter1, 16);
        chk("c0_out_esc", out_esc1, 0);
        accept1();
        chk("c0_out_val_after_accept", out_val1, 0);
        chk("c0_in_rdy_after_accept", in_rdy1, 1);

        // Single context, c=(1,1): z goes 0 -> (1,1) -> (1,3), |z|^2=10 escapes
        issue1(ONE, ONE, 8'd6);
        wait_val1(200, cyc);
        chk("c11_latency", cyc, 9);
        chk("c11_out_id", out_id1, 6);
        chk("c11_out_iter", out_iter1, 3);
        chk("c11_out_esc", out_esc1, 1);
        accept1();
`ifdef MANDEL_PERF_CNT_EN
        chk("perf_iters", perf1, 19);
`endif

        // Four contexts, back-to-back accepts; fast escapers return first
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("mc_in_rdy_before_accept", in_rdy4, 1);
            in_val4 = 1'b1;
            in_cr4  = tab_cr[k];
            in_ci4  = tab_ci[k];
            in_id4  = IDW'(k);
            @(posedge clk);
            #1;
        end
        in_val4 = 1'b0;
        chk("mc_in_rdy_full", in_rdy4, 0);

        wait_val4(100, cyc);
        chk("mc_first_val", out_val4, 1);
        chk("mc_first_id", out_id4, 3);
        chk("mc_first_iter", out_iter4, 2);
        chk("mc_first_esc", out_esc4, 1);
        accept4();
        chk("mc_in_rdy_freed", in_rdy4, 1);

        wait_val4(100, cyc);
        chk("mc_second_val", out_val4, 1);
        chk("mc_second_id", out_id4, 1);
        chk("mc_second_iter", out_iter4, 3);
        chk("mc_second_esc", out_esc4, 1);
        accept4();

        wait_val4(300, cyc);
        chk("mc_third_val", out_val4, 1);
        chk("mc_third_id", out_id4, 0);
        chk("mc_third_iter", out_iter4, 16);
        chk("mc_third_esc", out_esc4, 0);

        // Stall: presented result must not change while id 2 also finishes
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (out_val4 !== 1'b1 || out_id4 !== 8'd0 || out_iter4 !== 5'd16) begin
                stable = 1'b0;
            end
        end
        chk("stall_stable", stable, 1);
        accept4();
        chk("stall_next_val", out_val4, 1);
        chk("stall_next_id", out_id4, 2);
        chk("stall_next_iter", out_iter4, 16);
        accept4();
        chk("mc_drained", out_val4, 0);

        // Async reset mid-iteration with three contexts busy
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_val4 = 1'b1;
            in_cr4  = (k == 0) ? TWO_HALF : 32'd0;
            in_ci4  = 32'd0;
            in_id4  = IDW'(10 + k);
            @(posedge clk);
            #1;
        end
        in_val4 = 1'b0;
        wait_val4(100, cyc);
        chk("pre_rst_val", out_val4, 1);
        chk("pre_rst_id", out_id4, 10);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_val", out_val4, 0);
        chk("async_rst_in_rdy", in_rdy4, 0);
        chk("async_rst_out_id", out_id4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_rdy", in_rdy4, 1);
        stale = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(posedge clk);
            #1;
            if (out_val4 !== 1'b0) begin
                stale = 1'b1;
            end
        end
        chk("post_rst_no_stale", stale, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mandel_iter_ctx.md
# mandel_iter_ctx

Multi-context Mandelbrot escape-time iterator. It keeps NUM_CTX independent pixels in flight and time-multiplexes one shared fixed-point multiplier across them round-robin, so the multiplier is busy every cycle. It sits between the pixel-coordinate generator (upstream valid/ready) and the colour mapper / VGA writer (downstream valid/ready). Results return tagged and may complete out of order.

## Interface
- WIDTH, 27: fixed-point word width, signed, Q(WIDTH-FRAC).FRAC
- FRAC, 23: fraction bits
- ITER_MAX, 1000: iteration limit, ≥2
- NUM_CTX, 4: contexts in flight, ≥1
- ID_W, 8: tag width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- in_val  in  1  coordinate valid
- in_rdy  out  1  at least one context idle
- in_c_r  in  WIDTH  real part of c, signed
- in_c_i  in  WIDTH  imaginary part of c, signed
- in_id  in  ID_W  caller tag, returned with result
- out_val  out  1  result valid
- out_rdy  in  1  downstream accepts
- out_id  out  ID_W  tag of result
- out_iter  out  $clog2(ITER_MAX)+1  iterations executed
- out_escaped  out  1  1 = escaped, 0 = hit ITER_MAX

## Operation
- Per-context state: phase ∈ {IDLE, CALC_1, CALC_2, CALC_3, DONE}; zr, zi, c_r, c_i, zr_sq, zi_sq, iter, id, esc.
- Scheduler pointer ptr: counts 0..NUM_CTX-1 every cycle, wraps to 0.
- Multiplier inputs taken from context ptr: CALC_1 zr·zr → zr_sq; CALC_2 zi·zi → zi_sq; CALC_3 zr·zi, combined combinationally.
- Product: full 2·WIDTH signed; result = {p[2W-1], p[W+FRAC-2:FRAC]}, wraps, no saturation.
- CALC_3: zr ← zr_sq − zi_sq + c_r; zi ← (zr·zi <<< 1) + c_i; iter ← iter+1; if escape → DONE, else → CALC_1. The update happens on the escaping iteration as well.
- Escape is evaluated on pre-update values. It is the OR of:
  - mag = zr_sq + zi_sq > 4.0 (1<<(FRAC+2));
  - mag sign bit set (overflow);
  - iter == ITER_MAX−1.
- esc = 1 if a magnitude term fired, else 0.
- Load: on in_val && in_rdy, the lowest-index IDLE context takes c, id, clears z/sq/iter, and goes to CALC_1.
- Unload: out_sel latches the lowest-index DONE context when out_val rises. It stays locked until out_val && out_rdy; on acceptance that context → IDLE. Outputs stay stable while stalled.
- A context freed this cycle is not loadable until the next cycle. in_rdy is derived from the registered phases only.

## Timing
- Reset (asserted low, async): all contexts IDLE, ptr=0, all datapath registers 0, out_sel unlocked. in_rdy=0 and out_val=0 while reset is low; out_id/out_iter/out_escaped=0.
- in_rdy=1 from the first cycle after reset release.
- A context advances at most one phase per NUM_CTX cycles. Its first phase executes at the first edge after load with ptr == its index.
- One iteration takes exactly 3·NUM_CTX cycles. Accept-to-out_val is ≤ 3·NUM_CTX·n cycles for n iterations.
- out_val rises the cycle after the escaping CALC_3 edge.
- A DONE context does not advance and holds the multiplier slot idle on its ptr turns.
- All handshakes are combinational-ready / registered-state; there is no combinational in→out path.

## Configuration
- MANDEL_PERF_CNT_EN defined: adds output perf_iters (out, 32 bits). It counts every CALC_3 execution across all contexts, wraps at 2^32, and clears on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package mandel_pkg holds:
  - the phase enum;
  - fixed-point constants ONE_P (1<<FRAC), FOUR_P (1<<(FRAC+2));
  - the product bit-select function.
- One sub-module: mandel_fx_mult, a parametrised signed WIDTH×WIDTH multiply with the bit-select above, instantiated once.

## Test plan
- NUM_CTX=1, ITER_MAX=16, c=(0,0), id=5 → out_iter=16, out_escaped=0, out_id=5; latency 48 cycles.
- c=(1.0,1.0) → out_iter=3, out_escaped=1. The iteration-2 z=(1,3) is observed internally.
- NUM_CTX=4: issue ids 0..3 back-to-back with c=(0,0),(1,1),(0,0),(2.5,0) → in_rdy drops after 4 accepts. Id 3 (iter=2) and id 1 (iter=3) return before ids 0 and 2.
- out_rdy held 0 for 50 cycles while other contexts finish → out_id/out_iter unchanged until accept; the next DONE context is presented on the following cycle.
- Async reset pulsed mid-iteration with 3 contexts busy → out_val=0 and in_rdy=0 immediately. After release in_rdy=1 and no stale result appears.
- MANDEL_PERF_CNT_EN, ITER_MAX=16: pixels c=(1,1) and c=(0,0) → perf_iters=19.
